bit_serial_sub: RTL and testbench
=================================

BIT_SERIAL_SUB -- requirements
Module: bit_serial_sub

Interface
REQ-001 SHALL have parameter N, default 32, datapath width in bits; legal range N >= 1.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operands a, b, bi presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  N  minuend.
REQ-007 SHALL have port b  input  N  subtrahend.
REQ-008 SHALL have port bi  input  1  borrow in.
REQ-009 SHALL have port out_valid  output  1  result c/bo valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port c  output  N  difference a - b - bi, modulo 2^N.
REQ-012 SHALL have port bo  output  1  borrow out; 1 when a < b + bi (unsigned).
REQ-013 SHALL have port v  output  1  signed overflow; present only under the REQ-030 macro.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-015 SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-016 SHALL accept operands on the cycle where in_valid && in_ready; captures a, b, bi into internal shift registers; IDLE -> RUN.
REQ-017 SHALL in RUN process one bit per cycle, LSB first; per bit: d = a_i ^ b_i ^ br, br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br); br initialised to bi.
REQ-018 SHALL use a bit counter of width max(1, $clog2(N)) counting 0..N-1; RUN -> DONE on the cycle processing bit N-1.
REQ-019 SHALL assert out_valid exactly N cycles after the accepting edge (N=1: one cycle).
REQ-020 SHALL in DONE hold c, bo (and v) stable while out_valid && !out_ready.
REQ-021 SHALL on out_valid && out_ready transition DONE -> IDLE; in_ready returns high next cycle; no operand accepted in the handshake cycle.
REQ-022 SHALL ignore in_valid, a, b, bi outside IDLE; operand changes during RUN do not affect the result.
REQ-023 SHALL keep c, bo (and v) at the last completed result in IDLE and RUN; only valid when out_valid is high.

Reset
REQ-024 SHALL on rst assertion immediately (asynchronously) force state IDLE, counter 0, shift registers 0.
REQ-025 SHALL drive reset outputs: in_ready 1, out_valid 0, c 0, bo 0, v 0.
REQ-026 SHALL on rst asserted mid-RUN or in DONE abort the operation; no out_valid for the aborted operands.
REQ-027 SHALL leave reset synchronously with clk; first accept possible on first rising edge with rst low.

Configuration
REQ-028 SHALL be fully functional without any macro defined.
REQ-029 SHALL without macro BIT_SERIAL_SUB_OVERFLOW_EN omit port v and its logic.
REQ-030 SHALL with BIT_SERIAL_SUB_OVERFLOW_EN defined provide v = (a[N-1] != b[N-1]) && (c[N-1] != a[N-1]) for captured operands (borrow-in counted), updated with c at DONE entry.

Verification
REQ-031 SHALL cover, N=8: a=0x05, b=0x03, bi=0 -> out_valid 8 cycles after accept, c=0x02, bo=0.
REQ-032 SHALL cover, N=8: a=0x03, b=0x05, bi=0 -> c=0xFE, bo=1; a=0x00, b=0x00, bi=1 -> c=0xFF, bo=1.
REQ-033 SHALL cover, N=8, macro defined: a=0x80, b=0x01, bi=0 -> c=0x7F, bo=0, v=1; a=0x7F, b=0xFF -> c=0x80, bo=1, v=1.
REQ-034 SHALL cover backpressure: out_ready low 5 cycles in DONE -> c, bo stable, in_ready 0; in_valid toggled with new operands meanwhile -> ignored; out_ready high -> IDLE next cycle.
REQ-035 SHALL cover reset mid-RUN: rst pulsed 3 cycles after accept -> out_valid 0, c 0, in_ready 1 immediately; next operands a=0x10, b=0x01 -> c=0x0F, bo=0 after 8 cycles.
REQ-036 SHALL cover N=1: a=0, b=1, bi=0 -> out_valid 1 cycle after accept, c=1, bo=1; back-to-back ops with out_ready tied high -> one result every N+2 cycles.

Source files
------------

// File: rtl/bit_serial_sub.sv
// Bit-serial subtractor: computes a - b - bi one bit per cycle, LSB first, with a valid/ready handshake.
// Optional signed-overflow output v is enabled by defining BIT_SERIAL_SUB_OVERFLOW_EN.
module bit_serial_sub #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         bo
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
    ,
    output logic         v
`endif
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state, w_next;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_a, r_b, r_d, r_c;
    logic           r_br, r_bo;
    logic           w_d, w_br, w_last, w_accept;
    logic [N-1:0]   w_d_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN:     if (w_last) w_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_state == RUN) && (r_cnt == CW'(N - 1));
    assign w_d      = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br     = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

    // Difference bits enter at the MSB so the LSB lands at bit 0 after N shifts.
    always_comb begin
        w_d_shift        = '0;
        w_d_shift[N-1]   = w_d;
        for (int i = 0; i < N - 1; i++) w_d_shift[i] = r_d[i+1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_d   <= '0;
            r_br  <= 1'b0;
            r_c   <= '0;
            r_bo  <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_a   <= a;
            r_b   <= b;
            r_br  <= bi;
            r_d   <= '0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_br;
            r_d   <= w_d_shift;
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            if (w_last) begin
                r_c  <= w_d_shift;
                r_bo <= w_br;
            end
        end
    end

    assign c  = r_c;
    assign bo = r_bo;

`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
    logic r_amsb, r_bmsb, r_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_amsb <= 1'b0;
            r_bmsb <= 1'b0;
            r_v    <= 1'b0;
        end else if (w_accept) begin
            r_amsb <= a[N-1];
            r_bmsb <= b[N-1];
        end else if (w_last) begin
            // On the last bit w_d is the result MSB.
            r_v <= (r_amsb != r_bmsb) && (w_d != r_amsb);
        end
    end

    assign v = r_v;
`endif
endmodule

// File: tb/tb_bit_serial_sub.sv
// Scoreboard bench for bit_serial_sub: an N=8 instance for the main scenarios, an N=1 instance for back-to-back throughput.
module tb_bit_serial_sub;
    typedef struct {
        logic [7:0] c;
        logic       bo;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, out_ready = 1'b0, bi = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       in_ready, out_valid, bo;
    logic [7:0] c;
    logic       s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic [0:0] s_a = '0, s_b = '0;
    logic       s_bi = 1'b0;
    logic       s_in_ready, s_out_valid, s_bo;
    logic [0:0] s_c;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
    logic       v, s_v;
`endif

    int         checks = 0, failures = 0;
    exp_t       q[$];
    logic [1:0] sq[$];
    logic [7:0] last_c = '0;
    logic       last_bo = 1'b0;

    always #5 clk = ~clk;

    bit_serial_sub #(.N(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bi(bi), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .bo(bo)
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
        , .v(v)
`endif
    );

    bit_serial_sub #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .bi(s_bi), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .c(s_c), .bo(s_bo)
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
        , .v(s_v)
`endif
    );

    function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic mbi);
        exp_t       e;
        logic [8:0] t;
        t    = {1'b0, ma} - {1'b0, mb} - {8'b0, mbi};
        e.c  = t[7:0];
        e.bo = t[8];
        e.v  = (ma[7] != mb[7]) && (t[7] != ma[7]);
        return e;
    endfunction

    task automatic cmp_result(input string name);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL %s: result appeared with empty scoreboard", name);
            return;
        end
        e = q.pop_front();
        if (c !== e.c || bo !== e.bo) begin
            failures++;
            $display("FAIL %s: got c=%h bo=%b, want c=%h bo=%b", name, c, bo, e.c, e.bo);
        end
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
        checks++;
        if (v !== e.v) begin
            failures++;
            $display("FAIL %s_v: got v=%b, want v=%b", name, v, e.v);
        end
`endif
        last_c  = e.c;
        last_bo = e.bo;
    endtask

    // Accepts one operand set, scrambles inputs during RUN, checks latency and result.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbi,
                         input bit hs, input string name);
        int lat;
        lat = 0;
        while (!in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL %s_ready: in_ready=%b want 1", name, in_ready);
            return;
        end
        a = ta; b = tb_v; bi = tbi; in_valid = 1'b1;
        q.push_back(model(ta, tb_v, tbi));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
        checks++;
        if (c !== last_c || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_run_hold: c=%h in_ready=%b want c=%h in_ready=0", name, c, in_ready, last_c);
        end
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat != 8) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles want 8", name, lat);
        end
        if (out_valid) cmp_result(name);
        if (hs) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== last_c) begin
                failures++;
                $display("FAIL %s_handshake: in_ready=%b out_valid=%b c=%h want 1 0 %h",
                         name, in_ready, out_valid, c, last_c);
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== 8'h00 || bo !== 1'b0) begin
            failures++;
            $display("FAIL reset: in_ready=%b out_valid=%b c=%h bo=%b want 1 0 00 0", in_ready, out_valid, c, bo);
        end
        checks++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_c !== 1'b0 || s_bo !== 1'b0) begin
            failures++;
            $display("FAIL reset_n1: in_ready=%b out_valid=%b c=%b bo=%b want 1 0 0 0", s_in_ready, s_out_valid, s_c, s_bo);
        end
    endtask

    task automatic test_basic;
        do_op(8'h05, 8'h03, 1'b0, 1'b1, "sub_5_3");
        do_op(8'h03, 8'h05, 1'b0, 1'b1, "sub_3_5");
        do_op(8'h00, 8'h00, 1'b1, 1'b1, "sub_0_0_bi");
        do_op(8'hFF, 8'hFF, 1'b1, 1'b1, "sub_ff_ff_bi");
        for (int i = 0; i < 4; i++)
            do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, "sub_rand");
    endtask

    task automatic test_overflow;
        do_op(8'h80, 8'h01, 1'b0, 1'b1, "ovf_80_01");
        do_op(8'h7F, 8'hFF, 1'b0, 1'b1, "ovf_7f_ff");
    endtask

    task automatic test_backpressure;
        logic seen;
        do_op(8'h5A, 8'h3C, 1'b1, 1'b0, "bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || c !== last_c || bo !== last_bo) begin
                failures++;
                $display("FAIL bp_hold: out_valid=%b in_ready=%b c=%h bo=%b want 1 0 %h %b",
                         out_valid, in_ready, c, bo, last_c, last_bo);
            end
        end
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL bp_ignored: spurious activity seen=%b want 0", seen);
        end
    endtask

    task automatic test_reset_mid_run;
        a = 8'h44; b = 8'h11; bi = 1'b0; in_valid = 1'b1;
        q.push_back(model(8'h44, 8'h11, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || c !== 8'h00 || bo !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_run: out_valid=%b c=%h bo=%b in_ready=%b want 0 00 0 1", out_valid, c, bo, in_ready);
        end
        q.delete();
        last_c = 8'h00; last_bo = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        do_op(8'h10, 8'h01, 1'b0, 1'b1, "after_rst");
    endtask

    task automatic test_back_to_back_n1;
        int acc_cyc, prev_out, pushed, got;
        logic [2:0] combo;
        logic [1:0] e;
        acc_cyc = -10; prev_out = -1; pushed = 0; got = 0;
        s_out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            @(posedge clk); #1;
            if (s_out_valid) begin
                checks++;
                e = (sq.size() > 0) ? sq.pop_front() : 2'bxx;
                if ({s_bo, s_c} !== e || cyc - acc_cyc != 2) begin
                    failures++;
                    $display("FAIL n1_result: bo=%b c=%b lat=%0d want bo=%b c=%b lat=2",
                             s_bo, s_c, cyc - acc_cyc, e[1], e[0]);
                end
                if (prev_out >= 0) begin
                    checks++;
                    if (cyc - prev_out != 3) begin
                        failures++;
                        $display("FAIL n1_interval: got %0d cycles want 3", cyc - prev_out);
                    end
                end
                prev_out = cyc;
                got++;
            end
            if (s_in_ready) begin
                if (pushed < 8) begin
                    combo = 3'(pushed) ^ 3'b010;
                    s_a = combo[2]; s_b = combo[1]; s_bi = combo[0]; s_in_valid = 1'b1;
                    sq.push_back({1'b0, combo[2]} - {1'b0, combo[1]} - {1'b0, combo[0]});
                    acc_cyc = cyc;
                    pushed++;
                end else s_in_valid = 1'b0;
            end
        end
        s_in_valid = 1'b0; s_out_ready = 1'b0;
        checks++;
        if (got != 8) begin
            failures++;
            $display("FAIL n1_count: got %0d results want 8", got);
        end
    endtask

    initial begin
        #12 test_reset;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        test_basic;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
        test_overflow;
`endif
        test_backpressure;
        test_reset_mid_run;
        test_back_to_back_n1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
